// File: rtl/dfx_packet_reassembler_pkg.sv
// Shared header layout and derived-width helpers for the DFX packet reassembler.
package dfx_pkt_pkg;

   localparam int unsigned SRC_LSB = 0;

   function automatic int unsigned seq_lsb(input int unsigned src_w);
      return SRC_LSB + src_w;
   endfunction

   function automatic int unsigned payload_w(input int unsigned aurora_w, input int unsigned hdr_w);
      return aurora_w - hdr_w;
   endfunction

   function automatic int unsigned num_frag(input int unsigned dfx_w, input int unsigned pay_w);
      return (dfx_w + pay_w - 1) / pay_w;
   endfunction

   function automatic int unsigned last_w(input int unsigned dfx_w, input int unsigned pay_w);
      return dfx_w - (num_frag(dfx_w, pay_w) - 1) * pay_w;
   endfunction

   // Fields are wide enough for any legal configuration; callers keep the low SRC_W/SEQ_W bits.
   typedef struct packed {
      logic [7:0] seq;
      logic [7:0] src;
   } hdr_t;

   function automatic hdr_t hdr_decode(input logic [31:0] hdr, input int unsigned src_w,
                                       input int unsigned seq_w);
      hdr_t        h;
      logic [31:0] m_src;
      logic [31:0] m_seq;
      m_src = (32'd1 << src_w) - 32'd1;
      m_seq = (32'd1 << seq_w) - 32'd1;
      h.src = 8'((hdr >> SRC_LSB) & m_src);
      h.seq = 8'((hdr >> seq_lsb(src_w)) & m_seq);
      return h;
   endfunction

endpackage

// File: rtl/dfx_packet_reassembler_rr_arbiter.sv
// Round-robin arbiter: highest priority goes to the requester after the last accepted grant.
module rr_arbiter #(
   parameter  int unsigned NUM_SRC = 4,
   localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] req_i,
   input  logic               accept_i,
   output logic [NUM_SRC-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               valid_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   int unsigned      cand;

   assign valid_o = |req_i;

   // Scan lowest priority first so the highest-priority requester overwrites last.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      cand      = 0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         cand = (32'(ptr_q) + (NUM_SRC - 1 - i)) % NUM_SRC;
         if (req_i[cand]) gnt_idx_o = IDX_W'(cand);
      end
      if (valid_o) gnt_o[gnt_idx_o] = 1'b1;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept_i && valid_o)
         ptr_d = (32'(gnt_idx_o) == NUM_SRC - 1) ? '0 : gnt_idx_o + IDX_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/dfx_packet_reassembler.sv
// Streaming Aurora-beat to DFX-word reassembler with per-source buffers and round-robin output.
module dfx_packet_reassembler
   import dfx_pkt_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH        = 1024,
   parameter  int unsigned ADDR_WIDTH        = 10,
   parameter  int unsigned DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
   parameter  int unsigned AURORA_DATA_WIDTH = 256,
   parameter  int unsigned NUM_SRC           = 4,
   parameter  int unsigned HDR_W             = 7,
   localparam int unsigned SRC_W             = $clog2(NUM_SRC)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [AURORA_DATA_WIDTH-1:0] in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_DFX_WIDTH-1:0]    out_data,
   output logic [SRC_W-1:0]             out_src,
   output logic                         err_seq,
   output logic                         err_dup
);

   localparam int unsigned PAYLOAD_W = payload_w(AURORA_DATA_WIDTH, HDR_W);
   localparam int unsigned NUM_FRAG  = num_frag(DATA_DFX_WIDTH, PAYLOAD_W);
   localparam int unsigned LAST_W    = last_w(DATA_DFX_WIDTH, PAYLOAD_W);
   localparam int unsigned SEQ_W     = $clog2(NUM_FRAG);

   logic [31:0]                         hdr_bits;
   hdr_t                                hdr;
   logic                                unused_hdr_bits;
   logic [SRC_W-1:0]                    src;
   logic [SEQ_W-1:0]                    seq;
   logic [NUM_FRAG-1:0]                 seq_oh;
   logic                                seq_ok, accept, wr, dup;
   logic [PAYLOAD_W-1:0]                payload;

   logic [DATA_DFX_WIDTH-1:0]           buf_q [NUM_SRC];
   logic [NUM_SRC-1:0][NUM_FRAG-1:0]    frag_q, frag_d;
   logic [NUM_SRC-1:0]                  done_q, done_d;

   logic                                load, any_done;
   logic [NUM_SRC-1:0]                  gnt_oh;
   logic [SRC_W-1:0]                    gnt_idx;

   logic                                out_valid_q, err_seq_q, err_dup_q;
   logic [DATA_DFX_WIDTH-1:0]           out_data_q;
   logic [SRC_W-1:0]                    out_src_q;

   always_comb begin
      hdr_bits              = '0;
      hdr_bits[HDR_W-1:0]   = in_data[HDR_W-1:0];
   end

   assign hdr             = hdr_decode(hdr_bits, SRC_W, SEQ_W);
   assign unused_hdr_bits = ^{hdr.src[7:SRC_W], hdr.seq[7:SEQ_W]};
   assign src             = hdr.src[SRC_W-1:0];
   assign seq             = hdr.seq[SEQ_W-1:0];
   assign payload         = in_data[AURORA_DATA_WIDTH-1:HDR_W];
   assign seq_ok          = 32'(seq) < NUM_FRAG;

   always_comb begin
      seq_oh = '0;
      for (int unsigned f = 0; f < NUM_FRAG; f++) seq_oh[f] = (32'(seq) == f);
   end

   assign in_ready = !done_q[src];
   assign accept   = in_valid && in_ready;
   assign wr       = accept && seq_ok;
   assign dup      = wr && |(frag_q[src] & seq_oh);
   assign load     = any_done && (!out_valid_q || out_ready);

   rr_arbiter #(
      .NUM_SRC (NUM_SRC)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (done_q),
      .accept_i  (load),
      .gnt_o     (gnt_oh),
      .gnt_idx_o (gnt_idx),
      .valid_o   (any_done)
   );

   // A loading source is always done and hence never written in the same cycle.
   always_comb begin
      frag_d = frag_q;
      done_d = done_q;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         if (load && gnt_oh[s]) begin
            frag_d[s] = '0;
            done_d[s] = 1'b0;
         end
         if (wr && src == SRC_W'(s)) begin
            frag_d[s] = frag_q[s] | seq_oh;
            if (&frag_d[s]) done_d[s] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (src == SRC_W'(s)) begin
               for (int unsigned f = 0; f < NUM_FRAG - 1; f++)
                  if (seq_oh[f]) buf_q[s][f*PAYLOAD_W +: PAYLOAD_W] <= payload;
               if (seq_oh[NUM_FRAG-1])
                  buf_q[s][DATA_DFX_WIDTH-1 -: LAST_W] <= in_data[HDR_W +: LAST_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frag_q      <= '0;
         done_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         err_seq_q   <= 1'b0;
         err_dup_q   <= 1'b0;
      end else begin
         frag_q    <= frag_d;
         done_q    <= done_d;
         err_seq_q <= accept && !seq_ok;
         err_dup_q <= dup;
         if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= buf_q[gnt_idx];
            out_src_q   <= gnt_idx;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign err_seq   = err_seq_q;
   assign err_dup   = err_dup_q;

endmodule

// File: tb/tb_dfx_packet_reassembler.sv
// Directed vector table plus hand-written reset and latency sequences for dfx_packet_reassembler.
module tb_dfx_packet_reassembler;

   localparam int AW = 256;
   localparam int DW = 1034;
   localparam int PW = 249;
   localparam int LW = 38;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_ready, out_valid, out_ready, err_seq, err_dup;
   logic [AW-1:0] in_data;
   logic [DW-1:0] out_data;
   logic [1:0]    out_src;

   always #5 clk = ~clk;

   dfx_packet_reassembler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .err_seq   (err_seq),
      .err_dup   (err_dup)
   );

   typedef struct {
      logic          vld;
      logic [AW-1:0] data;
      logic          ordy;
      logic          e_rdy;
      logic          e_ov;
      logic [1:0]    e_src;
      logic [DW-1:0] e_data;
      logic          e_es;
      logic          e_ed;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic logic [PW-1:0] pl(int src, int seq, int salt);
      logic [255:0] t;
      for (int i = 0; i < 8; i++)
         t[i*32 +: 32] = {8'(32'hA5 ^ salt), 8'(src), 8'(seq), 8'(i * 17 + salt)};
      return t[PW-1:0];
   endfunction

   function automatic logic [AW-1:0] beat(int src, int seq, int resv, logic [PW-1:0] p);
      return {p, 2'(resv), 3'(seq), 2'(src)};
   endfunction

   // Expected word: payloads of seq 0..3 in order, then the low LW bits of seq 4 on top.
   function automatic logic [DW-1:0] word(int src, int salt);
      logic [PW-1:0] p4;
      p4 = pl(src, 4, salt);
      return {p4[LW-1:0], pl(src, 3, salt), pl(src, 2, salt), pl(src, 1, salt), pl(src, 0, salt)};
   endfunction

   function automatic void add(logic vld, logic [AW-1:0] d, logic ordy, logic e_rdy, logic e_ov,
                               int e_src, logic [DW-1:0] e_data, logic e_es, logic e_ed);
      vec_t v;
      v.vld = vld; v.data = d; v.ordy = ordy; v.e_rdy = e_rdy; v.e_ov = e_ov;
      v.e_src = 2'(e_src); v.e_data = e_data; v.e_es = e_es; v.e_ed = e_ed;
      vecs.push_back(v);
   endfunction

   task automatic chk(string nm, int idx, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_data(string nm, int idx, logic [DW-1:0] act, logic [DW-1:0] exp);
      logic [DW-1:0] sa, se, diff;
      int            b;
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         diff = act ^ exp;
         b    = 0;
         for (int i = DW - 1; i >= 0; i--) if (diff[i] !== 1'b0) b = i;
         sa = act >> b;
         se = exp >> b;
         $display("FAIL %s [%0d]: from bit %0d got %h expected %h", nm, idx, b, sa[31:0], se[31:0]);
      end
   endtask

   task automatic apply(int idx, vec_t v);
      @(negedge clk);
      in_valid  = v.vld;
      in_data   = v.data;
      out_ready = v.ordy;
      #1;
      chk("in_ready", idx, 64'(in_ready), 64'(v.e_rdy));
      chk("out_valid", idx, 64'(out_valid), 64'(v.e_ov));
      chk("err_seq", idx, 64'(err_seq), 64'(v.e_es));
      chk("err_dup", idx, 64'(err_dup), 64'(v.e_ed));
      if (v.e_ov) begin
         chk("out_src", idx, 64'(out_src), 64'(v.e_src));
         chk_data("out_data", idx, out_data, v.e_data);
      end
   endtask

   task automatic drive(logic vld, logic [AW-1:0] d, logic ordy);
      @(negedge clk);
      in_valid  = vld;
      in_data   = d;
      out_ready = ordy;
   endtask

   function automatic void build();
      int            ord[5] = '{4, 2, 0, 3, 1};
      logic [DW-1:0] dupw;
      // In-order word from src 2, then the stall/unstall of src 2 around its load.
      for (int q = 0; q < 5; q++) add(1, beat(2, q, 0, pl(2, q, 1)), 1, 1, 0, 0, '0, 0, 0);
      add(0, beat(2, 0, 0, '0), 1, 0, 0, 0, '0, 0, 0);
      add(0, beat(2, 0, 0, '0), 1, 1, 1, 2, word(2, 1), 0, 0);
      add(0, '0, 1, 1, 0, 0, '0, 0, 0);
      // Out-of-order word from src 1 with reserved header bits set.
      for (int q = 0; q < 5; q++) add(1, beat(1, ord[q], 3, pl(1, ord[q], 2)), 1, 1, 0, 0, '0, 0, 0);
      add(0, beat(1, 0, 0, '0), 1, 0, 0, 0, '0, 0, 0);
      add(0, beat(1, 0, 0, '0), 1, 1, 1, 1, word(1, 2), 0, 0);
      add(0, '0, 1, 1, 0, 0, '0, 0, 0);
      // All four sources interleaved, completing on consecutive cycles.
      for (int q = 0; q < 4; q++)
         for (int s = 0; s < 4; s++) add(1, beat(s, q, 0, pl(s, q, 3)), 1, 1, 0, 0, '0, 0, 0);
      add(1, beat(0, 4, 0, pl(0, 4, 3)), 1, 1, 0, 0, '0, 0, 0);
      add(1, beat(1, 4, 0, pl(1, 4, 3)), 1, 1, 0, 0, '0, 0, 0);
      add(1, beat(2, 4, 0, pl(2, 4, 3)), 1, 1, 1, 0, word(0, 3), 0, 0);
      add(1, beat(3, 4, 0, pl(3, 4, 3)), 1, 1, 1, 1, word(1, 3), 0, 0);
      add(0, '0, 1, 1, 1, 2, word(2, 3), 0, 0);
      add(0, '0, 1, 1, 1, 3, word(3, 3), 0, 0);
      add(0, '0, 1, 1, 0, 0, '0, 0, 0);
      // Backpressure: src 2 held in output, src 0 completes and stalls, src 3 keeps flowing.
      for (int q = 0; q < 5; q++) add(1, beat(2, q, 0, pl(2, q, 4)), 0, 1, 0, 0, '0, 0, 0);
      add(1, beat(0, 0, 0, pl(0, 0, 5)), 0, 1, 0, 0, '0, 0, 0);
      for (int q = 1; q < 5; q++) add(1, beat(0, q, 0, pl(0, q, 5)), 0, 1, 1, 2, word(2, 4), 0, 0);
      add(1, beat(0, 0, 0, pl(0, 0, 9)), 0, 0, 1, 2, word(2, 4), 0, 0);
      for (int q = 0; q < 5; q++) add(1, beat(3, q, 0, pl(3, q, 6)), 0, 1, 1, 2, word(2, 4), 0, 0);
      add(1, beat(0, 1, 0, pl(0, 1, 9)), 0, 0, 1, 2, word(2, 4), 0, 0);
      add(0, beat(0, 0, 0, '0), 1, 0, 1, 2, word(2, 4), 0, 0);
      add(0, beat(0, 0, 0, '0), 1, 0, 1, 3, word(3, 6), 0, 0);
      add(0, beat(0, 0, 0, '0), 1, 1, 1, 0, word(0, 5), 0, 0);
      add(0, '0, 1, 1, 0, 0, '0, 0, 0);
      // Bad sequence numbers, then a duplicated fragment whose later payload wins.
      add(1, beat(1, 5, 0, pl(1, 5, 7)), 1, 1, 0, 0, '0, 0, 0);
      add(1, beat(1, 6, 0, pl(1, 6, 7)), 1, 1, 0, 0, '0, 1, 0);
      add(1, beat(3, 0, 0, pl(3, 0, 7)), 1, 1, 0, 0, '0, 1, 0);
      add(1, beat(3, 1, 0, pl(3, 1, 7)), 1, 1, 0, 0, '0, 0, 0);
      add(1, beat(3, 2, 0, pl(3, 2, 7)), 1, 1, 0, 0, '0, 0, 0);
      add(1, beat(3, 2, 0, pl(3, 2, 8)), 1, 1, 0, 0, '0, 0, 0);
      add(1, beat(3, 3, 0, pl(3, 3, 7)), 1, 1, 0, 0, '0, 0, 1);
      add(1, beat(3, 4, 0, pl(3, 4, 7)), 1, 1, 0, 0, '0, 0, 0);
      add(0, '0, 1, 1, 0, 0, '0, 0, 0);
      dupw = word(3, 7);
      dupw[2*PW +: PW] = pl(3, 2, 8);
      add(0, '0, 1, 1, 1, 3, dupw, 0, 0);
      add(0, '0, 1, 1, 0, 0, '0, 0, 0);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int ord2[5] = '{3, 4, 0, 1, 2};
      int lat;
      int extra;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst out_valid", -1, 64'(out_valid), 64'd0);
      chk("rst out_src", -1, 64'(out_src), 64'd0);
      chk("rst err_seq", -1, 64'(err_seq), 64'd0);
      chk("rst err_dup", -1, 64'(err_dup), 64'd0);
      chk("rst in_ready", -1, 64'(in_ready), 64'd1);
      chk_data("rst out_data", -1, out_data, '0);
      @(negedge clk);
      rst_n = 1'b1;

      build();
      foreach (vecs[i]) apply(i, vecs[i]);

      // Mid-operation reset: a held src 2 word and a partial src 1 word must both vanish.
      for (int q = 0; q < 5; q++) drive(1, beat(2, q, 0, pl(2, q, 11)), 0);
      for (int q = 0; q < 3; q++) drive(1, beat(1, q, 0, pl(1, q, 9)), 0);
      #1;
      chk("pre-reset out_valid", 1000, 64'(out_valid), 64'd1);
      chk("pre-reset out_src", 1000, 64'(out_src), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst out_valid", 1001, 64'(out_valid), 64'd0);
      chk("async rst out_src", 1001, 64'(out_src), 64'd0);
      chk_data("async rst out_data", 1001, out_data, '0);
      drive(0, '0, 1);
      rst_n = 1'b1;

      for (int q = 0; q < 5; q++) begin
         drive(1, beat(1, ord2[q], 0, pl(1, ord2[q], 10)), 1);
         #1;
         chk("post-reset err_dup", 1010 + q, 64'(err_dup), 64'd0);
         chk("post-reset out_valid", 1010 + q, 64'(out_valid), 64'd0);
      end
      lat = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         lat++;
      end while (!out_valid && lat < 10);
      chk("post-reset latency", 1020, 64'(lat), 64'd2);
      chk("post-reset out_src", 1020, 64'(out_src), 64'd1);
      chk_data("post-reset out_data", 1020, out_data, word(1, 10));
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         if (out_valid) extra++;
      end
      chk("post-reset extra words", 1021, 64'(extra), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
